// File: rtl/master_cmd_queue.sv
// rtl/master_cmd_queue.sv - host command FIFO issuing one transaction at a time to a bus master port
// Optional WAIT-state watchdog: define CMD_QUEUE_TIMEOUT_EN.
module master_cmd_queue #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_mode,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [$clog2(DEPTH):0]  q_count,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic                    d_mode,
  output logic [ADDR_WIDTH-1:0]   d_addr,
  output logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH-1:0]   d_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("master_cmd_queue: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic          busy_seen;
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [EW-1:0] head;
  logic          push;
  logic          pop;
  logic          wait_done;
  logic          timed_out;

  assign cmd_ready = (q_count != CW'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state == ISSUE) & d_ready;
  assign head      = mem[rd_ptr];
  // a transaction is only complete once the port has been seen busy after accepting it
  assign wait_done = d_ready & busy_seen;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_mode, cmd_addr, cmd_wdata};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
    end
  end

`ifdef CMD_QUEUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt;

  // counter is zero on the first WAIT cycle; the last permitted cycle is TIMEOUT_CYCLES-1
  assign timed_out = (state == WAIT) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt <= '0;
    end else if (state != WAIT) begin
      wait_cnt <= '0;
    end else if (!timed_out) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_err <= 1'b0;
    end else if (state == WAIT && !d_mode && (wait_done || timed_out)) begin
      rsp_err <= !wait_done;
    end
  end
`else
  assign timed_out = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      busy_seen <= 1'b0;
      d_valid   <= 1'b0;
      d_mode    <= 1'b0;
      d_addr    <= '0;
      d_wdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (q_count != '0) begin
            {d_mode, d_addr, d_wdata} <= head;
            d_valid <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (d_ready) begin
            d_valid   <= 1'b0;
            busy_seen <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (!d_ready) begin
            busy_seen <= 1'b1;
          end
          if (wait_done) begin
            if (d_mode) begin
              state <= IDLE;
            end else begin
              rsp_rdata <= d_rdata;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end else if (timed_out) begin
            // abandoned reads still answer the host so it is never left waiting
            if (d_mode) begin
              state <= IDLE;
            end else begin
              rsp_rdata <= '0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_master_cmd_queue.sv
// tb/tb_master_cmd_queue.sv - self-checking bench for master_cmd_queue
`timescale 1ns/1ps
module tb_master_cmd_queue;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int DEPTH = 4;
`ifdef CMD_QUEUE_TIMEOUT_EN
  localparam int TB_TO = 16;
`else
  localparam int TB_TO = 1024;
`endif

  logic          clk;
  logic          rstn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_mode;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [2:0]    q_count;
  logic          d_valid;
  logic          d_ready;
  logic          d_mode;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;

  master_cmd_queue #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TB_TO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .q_count(q_count),
    .d_valid(d_valid), .d_ready(d_ready), .d_mode(d_mode), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata)
  );

  typedef struct packed {
    logic          mode;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  typedef struct {
    logic          mode;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            busy;
    int            hold;
    logic          exp_rsp;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;

  cmd_t exp_cmd_q[$];
  rsp_t rsp_exp[$];
  logic [DW-1:0] smem [logic [AW-1:0]];

  // bus-port model controls and state
  logic s_hold;
  int   s_busy;
  int   s_phase;
  int   s_cnt;
  int   s_acc_cyc;
  int   s_done_cyc;
  cmd_t s_cur;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (smem.exists(a)) return smem[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // memory-like master port: accepts, stays busy s_busy cycles, then completes
  initial begin
    cmd_t c;
    d_ready = 1'b1;
    d_rdata = '0;
    s_phase = 0;
    s_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        d_ready = 1'b1;
        s_phase = 0;
        exp_cmd_q.delete();
        rsp_exp.delete();
      end else begin
        case (s_phase)
          0: begin
            d_rdata = DW'($urandom);
            d_ready = !s_hold;
            if (d_valid && d_ready) begin
              check("issue_expected", exp_cmd_q.size() != 0, 1);
              if (exp_cmd_q.size() != 0) begin
                c = exp_cmd_q.pop_front();
                check("issue_mode", d_mode, c.mode);
                check("issue_addr", d_addr, c.addr);
                if (c.mode) check("issue_wdata", d_wdata, c.wdata);
              end else begin
                c = {d_mode, d_addr, d_wdata};
              end
              s_cur = c;
              s_acc_cyc = cyc;
              s_cnt = s_busy;
              if (s_busy > 0) s_phase = 1;
              else if (!c.mode) rsp_exp.push_back({8'h00, 1'b1});
            end
          end
          1: begin
            d_ready = 1'b0;
            s_cnt--;
            if (s_cnt <= 0) s_phase = 2;
          end
          default: begin
            d_ready = 1'b1;
            if (s_cur.mode) begin
              smem[s_cur.addr] = s_cur.wdata;
            end else begin
              d_rdata = mem_rd(s_cur.addr);
              rsp_exp.push_back({d_rdata, 1'b0});
            end
            s_done_cyc = cyc;
            s_phase = 0;
          end
        endcase
      end
    end
  end

  // response scoreboard: only reads may answer, in order, with the modelled data
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rstn && rsp_valid) begin
        check("rsp_expected", rsp_exp.size() != 0, 1);
        if (rsp_ready && rsp_exp.size() != 0) begin
          r = rsp_exp.pop_front();
          check("rsp_rdata", rsp_rdata, r.rdata);
          check("rsp_err", rsp_err, r.err);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] w,
                           output logic acc);
    cmd_valid = 1'b1;
    cmd_mode = m;
    cmd_addr = a;
    cmd_wdata = w;
    acc = cmd_ready;
    if (acc) exp_cmd_q.push_back({m, a, w});
  endtask

  function automatic logic idle_now();
    return exp_cmd_q.size() == 0 && rsp_exp.size() == 0 && s_phase == 0 &&
           !d_valid && !rsp_valid && q_count == 0;
  endfunction

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (!idle_now() && n < bound) begin
      tick;
      n++;
    end
    check({tag, "_drain"}, idle_now(), 1);
    tick;
    tick;
  endtask

  task automatic run_one(input vec_t v, input int idx);
    logic acc;
    logic saw;
    int n;
    s_busy = v.busy;
    rsp_ready = (v.hold == 0);
    drive_cmd(v.mode, v.addr, v.wdata, acc);
    check($sformatf("v%0d_accept", idx), acc, 1);
    tick;
    cmd_valid = 1'b0;
    check($sformatf("v%0d_count1", idx), q_count, 1);
    check($sformatf("v%0d_dvalid_c1", idx), d_valid, 0);
    tick;
    check($sformatf("v%0d_dvalid_c2", idx), d_valid, 1);
    check($sformatf("v%0d_dmode", idx), d_mode, v.mode);
    check($sformatf("v%0d_daddr", idx), d_addr, v.addr);
    if (v.mode) check($sformatf("v%0d_dwdata", idx), d_wdata, v.wdata);
    tick;
    check($sformatf("v%0d_dvalid_drop", idx), d_valid, 0);
    check($sformatf("v%0d_count0", idx), q_count, 0);
    if (v.exp_rsp) begin
      n = 0;
      while (!rsp_valid && n < 200) begin
        tick;
        n++;
      end
      check($sformatf("v%0d_rsp_seen", idx), rsp_valid, 1);
      check($sformatf("v%0d_rsp_latency", idx), cyc, s_done_cyc + 1);
      check($sformatf("v%0d_rsp_rdata", idx), rsp_rdata, v.exp_rdata);
      check($sformatf("v%0d_rsp_err", idx), rsp_err, 0);
      for (int h = 0; h < v.hold; h++) begin
        tick;
        check($sformatf("v%0d_hold_valid", idx), rsp_valid, 1);
        check($sformatf("v%0d_hold_rdata", idx), rsp_rdata, v.exp_rdata);
      end
      rsp_ready = 1'b1;
      tick;
      check($sformatf("v%0d_rsp_clear", idx), rsp_valid, 0);
    end else begin
      saw = 1'b0;
      n = 0;
      while (!idle_now() && n < 200) begin
        saw = saw | rsp_valid;
        tick;
        n++;
      end
      check($sformatf("v%0d_write_no_rsp", idx), saw, 0);
    end
    wait_idle($sformatf("v%0d", idx), 200);
  endtask

  initial begin
    vec_t vt [6];
    logic acc;
    int n;

    vt[0] = '{1'b1, 16'h1234, 8'hA5, 20, 0, 1'b0, 8'h00};
    vt[1] = '{1'b0, 16'h2010, 8'h00, 3,  5, 1'b1, 8'h3C};
    vt[2] = '{1'b0, 16'h1234, 8'h00, 1,  0, 1'b1, 8'hA5};
    vt[3] = '{1'b1, 16'h0042, 8'h77, 2,  0, 1'b0, 8'h00};
    vt[4] = '{1'b0, 16'h0042, 8'h00, 4,  2, 1'b1, 8'h77};
    vt[5] = '{1'b0, 16'h0300, 8'h00, 1,  0, 1'b1, 8'h59};

    smem[16'h2010] = 8'h3C;
    rstn = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    s_hold = 1'b0;
    s_busy = 1;

    repeat (2) @(posedge clk);
    #1;
    check("reset_d_valid", d_valid, 0);
    check("reset_d_mode", d_mode, 0);
    check("reset_d_addr", d_addr, 0);
    check("reset_d_wdata", d_wdata, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_rsp_err", rsp_err, 0);
    check("reset_q_count", q_count, 0);
    check("reset_cmd_ready", cmd_ready, 1);
    rstn = 1'b1;
    tick;

    for (int i = 0; i < 6; i++) run_one(vt[i], i);

    // fill to DEPTH with the port stalled, reject the fifth, then drain; three rounds wrap pointers
    for (int r = 0; r < 3; r++) begin
      s_hold = 1'b1;
      s_busy = 1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
        drive_cmd(i[0], 16'h4000 + AW'(r * 16 + i), DW'($urandom), acc);
        if (i < 4) begin
          check($sformatf("full_r%0d_accept%0d", r, i), acc, 1);
        end else begin
          check($sformatf("full_r%0d_reject", r), acc, 0);
          check($sformatf("full_r%0d_count", r), q_count, 4);
        end
        tick;
      end
      cmd_valid = 1'b0;
      check($sformatf("full_r%0d_ready_low", r), cmd_ready, 0);
      s_hold = 1'b0;
      wait_idle($sformatf("full_r%0d", r), 300);
    end

    // simultaneous push and pop at occupancy 2
    s_hold = 1'b1;
    s_busy = 2;
    drive_cmd(1'b1, 16'h7000, 8'h01, acc);
    tick;
    drive_cmd(1'b0, 16'h7001, 8'h00, acc);
    tick;
    cmd_valid = 1'b0;
    tick;
    tick;
    check("pp_pre_count", q_count, 2);
    check("pp_pre_issue", d_valid, 1);
    s_hold = 1'b0;
    drive_cmd(1'b1, 16'h7002, 8'h03, acc);
    check("pp_accept", acc, 1);
    tick;
    cmd_valid = 1'b0;
    check("pp_count", q_count, 2);
    wait_idle("pp", 200);

    // asynchronous reset in the middle of a read with three commands queued
    s_busy = 30;
    drive_cmd(1'b0, 16'h6000, 8'h00, acc);
    tick;
    drive_cmd(1'b1, 16'h6001, 8'h11, acc);
    tick;
    drive_cmd(1'b0, 16'h6002, 8'h00, acc);
    tick;
    drive_cmd(1'b1, 16'h6003, 8'h22, acc);
    tick;
    cmd_valid = 1'b0;
    repeat (3) tick;
    check("rst_pre_count", q_count, 3);
    check("rst_pre_wait", d_valid, 0);
    rstn = 1'b0;
    #1;
    check("rst_d_valid", d_valid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_q_count", q_count, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_d_addr", d_addr, 0);
    tick;
    tick;
    rstn = 1'b1;
    s_busy = 1;
    for (int i = 0; i < 10; i++) begin
      tick;
      check("rst_no_residual_issue", d_valid, 0);
      check("rst_no_residual_count", q_count, 0);
    end

`ifdef CMD_QUEUE_TIMEOUT_EN
    // port never drops d_ready after accepting a read
    s_busy = 0;
    rsp_ready = 1'b1;
    drive_cmd(1'b0, 16'h5000, 8'h00, acc);
    tick;
    drive_cmd(1'b1, 16'h5001, 8'h44, acc);
    tick;
    cmd_valid = 1'b0;
    n = 0;
    while (exp_cmd_q.size() != 1 && n < 50) begin
      tick;
      n++;
    end
    check("to_read_accepted", exp_cmd_q.size(), 1);
    s_busy = 2;
    n = 0;
    while (!rsp_valid && n < 100) begin
      tick;
      n++;
    end
    check("to_rsp_seen", rsp_valid, 1);
    check("to_rsp_latency", cyc, s_acc_cyc + TB_TO + 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    wait_idle("to", 200);
`endif

    // randomized traffic against the in-order queue/memory model
    for (int i = 0; i < 600; i++) begin
      check("rand_q_count", q_count, exp_cmd_q.size());
      check("rand_cmd_ready", cmd_ready, exp_cmd_q.size() != DEPTH);
      rsp_ready = ($urandom_range(0, 3) != 0);
      s_busy = $urandom_range(1, 5);
      if ($urandom_range(0, 1) == 1) begin
        drive_cmd(1'($urandom_range(0, 1)), 16'h0100 + AW'($urandom_range(0, 7)),
                  DW'($urandom), acc);
      end else begin
        cmd_valid = 1'b0;
      end
      tick;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle("rand", 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/master_cmd_queue.md
# master_cmd_queue

Command front-end placed directly upstream of one master port of the two-master / three-slave serial system bus. It buffers host read/write commands in a small FIFO and issues them one at a time on the master port's device-side valid/ready interface (data, address, valid, ready, read/write mode, read data). It waits for each transaction to complete and returns read data to the host on a separate response handshake. One instance is used per master, and it connects to the device-side pins of the bus top level.

## Interface
- ADDR_WIDTH, 16, device address width (matches bus top)
- DATA_WIDTH, 8, data width
- DEPTH, 4, command FIFO entries; power of two, ≥2
- TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit (used only with macro)

- clk  in  1  clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  queue can accept (= not full)
- cmd_mode  in  1  0 read, 1 write
- cmd_addr  in  ADDR_WIDTH  command address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  host accepts response
- rsp_rdata  out  DATA_WIDTH  read data
- rsp_err  out  1  response produced by timeout
- q_count  out  $clog2(DEPTH)+1  FIFO occupancy
- d_valid  out  1  to master port dvalid
- d_ready  in  1  from master port dready
- d_mode  out  1  to master port dmode
- d_addr  out  ADDR_WIDTH  to master port daddr
- d_wdata  out  DATA_WIDTH  to master port dwdata
- d_rdata  in  DATA_WIDTH  from master port drdata

## Operation
- FIFO:
  - push on cmd_valid & cmd_ready; entry = {mode, addr, wdata}.
  - Pop when the FSM leaves ISSUE.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
  - cmd_ready = (q_count != DEPTH); a push is never accepted while full, even if a pop occurs in the same cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if q_count≠0, load the FIFO head into the d_mode/d_addr/d_wdata registers and go to ISSUE.
  - ISSUE: d_valid=1, d_* held stable. When d_ready=1, pop and go to WAIT, clearing busy_seen.
  - WAIT: d_valid=0.
    - If d_ready=0, set busy_seen.
    - If d_ready=1 and busy_seen: transaction complete.
      - Write: go to IDLE.
      - Read: capture d_rdata into rsp_rdata, set rsp_err=0, go to RESP.
  - RESP: rsp_valid=1, rsp_rdata held stable. On rsp_ready go to IDLE and clear rsp_valid.
- Writes never produce a response.
- The next command is not issued until the host has accepted the read response; commands complete strictly in order.
- Reset (asynchronous, any state, including mid-transaction):
  - FSM returns to IDLE; FIFO is emptied; contents are discarded.
  - All outputs take their reset values immediately: d_valid 0, d_mode 0, d_addr 0, d_wdata 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, q_count 0, cmd_ready 1.

## Timing
- Empty queue, IDLE, cmd handshake in cycle 0: IDLE sees non-empty in cycle 1; d_valid=1 in cycle 2.
- d_valid stays high from ISSUE entry until the cycle d_ready is sampled 1 (inclusive). It drops in the following cycle.
- Read completion in cycle k (WAIT, d_ready=1, busy_seen): rsp_valid=1 and rsp_rdata=d_rdata(k) from cycle k+1.
- Back-to-back writes: minimum 1 IDLE cycle between WAIT completion and the next ISSUE.
- q_count and cmd_ready update the cycle after a push or pop.

## Configuration
- CMD_QUEUE_TIMEOUT_EN defined:
  - A counter runs in WAIT and clears on WAIT entry.
  - When it reaches TIMEOUT_CYCLES without completion, the FSM abandons the transaction.
    - Read: go to RESP with rsp_rdata=0, rsp_err=1.
    - Write: go to IDLE.
  - This covers a master port that never drops or never restores d_ready.
- CMD_QUEUE_TIMEOUT_EN undefined:
  - No counter; WAIT persists until completion.
  - rsp_err is tied to 0.

## Test plan
- Reset, then one write (addr 0x1234, data 0xA5); model drops d_ready for 20 cycles -> d_valid in cycle 2 with d_addr=0x1234, d_wdata=0xA5, d_mode=1; no rsp_valid; q_count returns to 0.
- Read at 0x2010; model returns 0x3C when d_ready rises -> rsp_valid one cycle later with rsp_rdata=0x3C, rsp_err=0; held for 5 cycles while rsp_ready=0; cleared the cycle after rsp_ready.
- Push 5 commands back-to-back with d_ready held 0 (DEPTH=4) -> cmd_ready=0 after the 4th push and the 5th is not accepted; all 4 are issued in order, with pointer wrap checked over 3 full rounds.
- Simultaneous push and pop at q_count=2 -> q_count stays 2; issue order is preserved.
- Assert rstn low during WAIT of a read with 3 commands queued -> d_valid, rsp_valid, and q_count go to 0 immediately, cmd_ready=1; after release there is no residual issue.
- With CMD_QUEUE_TIMEOUT_EN and TIMEOUT_CYCLES=16, d_ready never drops after accepting a read -> rsp_valid with rsp_err=1, rsp_rdata=0 after 16 WAIT cycles; the next queued command then issues.
